// File: rtl/inv_shiftrows_if.sv
// Byte-stream bus between the AES inverse-cipher stages: one state byte per beat,
// valid-only (no backpressure), with an end-of-block marker on the output side.
interface inv_shiftrows_if;
    logic [7:0] inbyte;
    logic       enable;
    logic [7:0] outbyte;
    logic       ready;
    logic       last;

    modport slave (
        input  inbyte,
        input  enable,
        output outbyte,
        output ready,
        output last
    );

    modport master (
        output inbyte,
        output enable,
        input  outbyte,
        input  ready,
        input  last
    );
endinterface

// File: rtl/inv_shiftrows.sv
// Byte-serial AES (Inv)ShiftRows with ping-pong 16-byte banks; first output byte one cycle
// after the 16th input edge, 16 back-to-back output beats; no backpressure, input never stalls.
module inv_shiftrows #(
    parameter bit INVERSE = 1'b1
) (
    input  logic           clock,
    input  logic           resetn,
    inv_shiftrows_if.slave bus
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    // Source byte for output position n lives at nibble n; listed from n=15 down to n=0.
    localparam logic [63:0] INV_LUT = {4'd3,  4'd6,  4'd9,  4'd12, 4'd15, 4'd2,  4'd5,  4'd8,
                                       4'd11, 4'd14, 4'd1,  4'd4,  4'd7,  4'd10, 4'd13, 4'd0};
    localparam logic [63:0] FWD_LUT = {4'd11, 4'd6,  4'd1,  4'd12, 4'd7,  4'd2,  4'd13, 4'd8,
                                       4'd3,  4'd14, 4'd9,  4'd4,  4'd15, 4'd10, 4'd5,  4'd0};
    localparam logic [63:0] MAP_LUT = INVERSE ? INV_LUT : FWD_LUT;

    logic [7:0] mem_q [2][16];
    logic [7:0] mem_d [2][16];
    logic [3:0] wcnt_q, wcnt_d;
    logic [3:0] rcnt_q, rcnt_d;
    logic       bank_q, bank_d;
    logic [0:0] state_q, state_d;
    logic [7:0] outbyte_q, outbyte_d;
    logic       ready_q, ready_d;
    logic       last_q, last_d;

    logic       blk_done;
    logic [3:0] rd_idx;

    assign blk_done = bus.enable && (wcnt_q == 4'd15);
    assign rd_idx   = MAP_LUT[{rcnt_q, 2'b00} +: 4];

    always_comb begin
        mem_d     = mem_q;
        wcnt_d    = wcnt_q;
        rcnt_d    = rcnt_q;
        bank_d    = bank_q;
        state_d   = state_q;
        outbyte_d = outbyte_q;
        ready_d   = 1'b0;
        last_d    = 1'b0;

        if (bus.enable) begin
            mem_d[bank_q][wcnt_q] = bus.inbyte;
            wcnt_d                = wcnt_q + 4'd1;
        end

        // The reader always uses the bank opposite the one being filled.
        if (state_q == ST_STREAM) begin
            outbyte_d = mem_q[~bank_q][rd_idx];
            ready_d   = 1'b1;
            last_d    = (rcnt_q == 4'd15);
            rcnt_d    = rcnt_q + 4'd1;
            if (rcnt_q == 4'd15) begin
                state_d = ST_IDLE;
            end
        end

        // A completion on the final stream edge overrides the return to IDLE: no bubble.
        if (blk_done) begin
            bank_d  = ~bank_q;
            state_d = ST_STREAM;
            rcnt_d  = 4'd0;
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wcnt_q    <= 4'd0;
            rcnt_q    <= 4'd0;
            bank_q    <= 1'b0;
            state_q   <= ST_IDLE;
            outbyte_q <= 8'h00;
            ready_q   <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            wcnt_q    <= wcnt_d;
            rcnt_q    <= rcnt_d;
            bank_q    <= bank_d;
            state_q   <= state_d;
            outbyte_q <= outbyte_d;
            ready_q   <= ready_d;
            last_q    <= last_d;
        end
    end

    assign bus.outbyte = outbyte_q;
    assign bus.ready   = ready_q;
    assign bus.last    = last_q;

endmodule
